my_slave_mem: RTL

MY_SLAVE_MEM -- requirements
Module: my_slave_mem

---
 rtl/my_slave_mem.sv | 127 ++++++++++++
 1 files changed

// File: rtl/my_slave_mem.sv
// my_slave_mem: AHB-Lite style slave with 16 x 32-bit words in a 64-byte window.
//   Each OKAY data phase is stretched by WAIT_STATES wait cycles. A transfer that
//   falls outside the window, is not word aligned, or is not word sized gets a
//   two-cycle ERROR response and never touches storage.
// Ports:
//   HCLK, HRESET       clock, asynchronous active-high reset
//   HSEL, HADDR,       address phase: select, byte address, transfer type,
//   HTRANS, HWRITE,    direction and size, qualified by HREADY
//   HSIZE, HREADY
//   HWDATA             write data (data phase)
//   HRDATA             read data, non-zero only in the last cycle of a read
//   HREADYOUT, HRESP   slave ready / response (0 OKAY, 1 ERROR)
module my_slave_mem #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  typedef enum logic [2:0] {IDLE, WAIT, LAST, ERR1, ERR2} state_t;

  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t      state;
  logic [3:0]  cnt;
  logic [3:0]  idx_q;
  logic        wr_q;
  logic [31:0] mem [16];

  logic        accept;
  logic        addr_err;
  logic [31:0] fwd;
  logic        unused_ok;

  // Only NONSEQ/SEQ matter; HTRANS[0] distinguishes nothing we care about.
  assign unused_ok = HTRANS[0];

  assign accept   = HSEL && HTRANS[1] && HREADY;
  assign addr_err = (HADDR[31:6] != BASE_ADDR[31:6]) || (HADDR[1:0] != 2'b00) ||
                    (HSIZE != 3'b010);

  // With zero wait states a read can land in LAST on the very edge that commits
  // the previous write, so the write data is bypassed into the read register.
  always_comb begin
    fwd = mem[HADDR[5:2]];
    if (state == LAST && wr_q && idx_q == HADDR[5:2]) fwd = HWDATA;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      idx_q     <= 4'd0;
      wr_q      <= 1'b0;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      HRDATA    <= 32'd0;
      for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
    end else begin
      // Write data is valid in LAST; it is committed on the edge that ends it.
      if (state == LAST && wr_q) mem[idx_q] <= HWDATA;

      case (state)
        IDLE, LAST, ERR2: begin
          if (accept) begin
            idx_q <= HADDR[5:2];
            wr_q  <= HWRITE;
            if (addr_err) begin
              state     <= ERR1;
              HREADYOUT <= 1'b0;
              HRESP     <= 1'b1;
              HRDATA    <= 32'd0;
            end else if (WAIT_STATES > 0) begin
              state     <= WAIT;
              cnt       <= CNT_INIT;
              HREADYOUT <= 1'b0;
              HRESP     <= 1'b0;
              HRDATA    <= 32'd0;
            end else begin
              state     <= LAST;
              HREADYOUT <= 1'b1;
              HRESP     <= 1'b0;
              HRDATA    <= HWRITE ? 32'd0 : fwd;
            end
          end else begin
            state     <= IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            HRDATA    <= 32'd0;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state     <= LAST;
            HREADYOUT <= 1'b1;
            HRDATA    <= wr_q ? 32'd0 : mem[idx_q];
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ERR1: begin
          state     <= ERR2;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b0;
          HRDATA    <= 32'd0;
        end
      endcase
    end
  end

endmodule
